// File: rtl/dm_pkg.sv
// Shared debug-module types and helpers for the system-bus access engine.
//   sberror_e   : sticky SBA error codes reported to the debugger
//   sba_state_e : SBA engine states
//   sba_be      : byte enables for an access of 2**size bytes at lane offset off
//   sba_lane_up : move LSB-justified write data onto its byte lanes
//   sba_lane_dn : pull read data off its byte lanes, LSB-justified, zero-extended
// Helpers operate on the widest legal bus (128 bits / 16 lanes); callers
// truncate the result to their own bus width.
package dm_pkg;

  typedef enum logic [2:0] {
    SbErrNone       = 3'd0,
    SbErrTimeout    = 3'd1,
    SbErrBadAddr    = 3'd2,
    SbErrMisaligned = 3'd3,
    SbErrBadSize    = 3'd4
  } sberror_e;

  typedef enum logic [1:0] {
    SbaIdle,
    SbaReq,
    SbaWait,
    SbaDrain
  } sba_state_e;

  function automatic logic [15:0] sba_be(input logic [3:0] off, input logic [2:0] size);
    logic [15:0] m;
    case (size)
      3'd0:    m = 16'h0001;
      3'd1:    m = 16'h0003;
      3'd2:    m = 16'h000F;
      3'd3:    m = 16'h00FF;
      default: m = 16'hFFFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [127:0] sba_lane_up(input logic [127:0] d, input logic [3:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic logic [127:0] sba_lane_dn(input logic [127:0] d, input logic [3:0] off,
                                               input logic [2:0] size);
    logic [127:0] s;
    s = d >> {off, 3'b000};
    case (size)
      3'd0:    s = s & 128'h0000_0000_0000_0000_0000_0000_0000_00FF;
      3'd1:    s = s & 128'h0000_0000_0000_0000_0000_0000_0000_FFFF;
      3'd2:    s = s & 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
      3'd3:    s = s & 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
      default: s = s;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dm_sba_ctrl.sv
// System-bus access master for the debug module. Runs one debugger-initiated
// read or write at a time on a req/gnt/r_valid bus, aligning data to byte
// lanes and reporting sticky errors back to the SB registers.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   dmactive_i             : debug module active; low acts as a soft reset
//   master_*               : system bus master port
//   sbaddress_*, sbdata_*,
//   sbreadon*, sbaccess_i,
//   sbautoincrement_i      : SB register contents and debugger access strobes
//   sbaddress_o/_valid_o   : auto-incremented address for sbaddress
//   sbdata_o/_valid_o      : read data for sbdata
//   sbbusy_o, sbbusyerror_o, sberror_o and their clears : status
module dm_sba_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  output logic                  master_req_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadondata_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbdata_write_valid_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic                  sbaddress_valid_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sbbusyerror_o,
  input  logic                  sbbusyerror_clear_i,
  output logic [2:0]            sberror_o,
  input  logic                  sberror_clear_i
);

  localparam int unsigned BeW   = BusWidth / 8;
  localparam int unsigned OffW  = $clog2(BeW);
  // Counter must hold TimeoutCycles: a grant on the last Req cycle enters Wait one count later.
  localparam int unsigned CntW  = $clog2(TimeoutCycles + 2);
  localparam int unsigned TLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  sba_state_e          state_q;
  sberror_e            sberror_q;
  logic [BusWidth-1:0] addr_q, wdata_q, sbaddress_q, sbdata_q;
  logic [2:0]          size_q;
  logic                we_q, sbbusyerror_q, sbaddress_valid_q, sbdata_valid_q;
  logic [CntW-1:0]     cnt_q;

  logic [3:0] off;
  logic       start_wr, start_rd, dbg_any, start, size_bad, misaligned, timeout_hit;

  assign off      = 4'(addr_q[OffW-1:0]);
  assign start_wr = sbdata_write_valid_i;
  assign start_rd = (sbdata_read_valid_i && sbreadondata_i) ||
                    (sbaddress_write_valid_i && sbreadonaddr_i);
  assign dbg_any  = sbdata_write_valid_i || sbdata_read_valid_i || sbaddress_write_valid_i;
  // Sticky errors lock out new accesses until the debugger clears them.
  assign start    = (start_wr || start_rd) && dmactive_i &&
                    (sberror_q == SbErrNone) && !sbbusyerror_q;

  assign size_bad   = (sbaccess_i > 3'd4) || ((32'd1 << sbaccess_i) > BeW);
  assign misaligned = (sbaddress_i[3:0] & ((4'd1 << sbaccess_i) - 4'd1)) != 4'd0;
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q >= CntW'(TLast));

  // Bus outputs are decoded from registered state only; nothing is driven outside Req.
  assign master_req_o   = (state_q == SbaReq);
  assign master_add_o   = master_req_o ? addr_q : '0;
  assign master_we_o    = master_req_o && we_q;
  assign master_wdata_o = master_req_o ? BusWidth'(sba_lane_up(128'(wdata_q), off)) : '0;
  assign master_be_o    = master_req_o ? BeW'(sba_be(off, size_q)) : '0;

  assign sbbusy_o          = (state_q != SbaIdle);
  assign sbbusyerror_o     = sbbusyerror_q;
  assign sberror_o         = sberror_q;
  assign sbaddress_o       = sbaddress_q;
  assign sbaddress_valid_o = sbaddress_valid_q;
  assign sbdata_o          = sbdata_q;
  assign sbdata_valid_o    = sbdata_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= SbaIdle;
      sberror_q         <= SbErrNone;
      sbbusyerror_q     <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      size_q            <= '0;
      we_q              <= 1'b0;
      cnt_q             <= '0;
      sbaddress_q       <= '0;
      sbaddress_valid_q <= 1'b0;
      sbdata_q          <= '0;
      sbdata_valid_q    <= 1'b0;
    end else begin
      sbaddress_valid_q <= 1'b0;
      sbdata_valid_q    <= 1'b0;
      // Clears first so that any set later in this block wins.
      if (sberror_clear_i)     sberror_q     <= SbErrNone;
      if (sbbusyerror_clear_i) sbbusyerror_q <= 1'b0;
      if (sbbusy_o && dbg_any) sbbusyerror_q <= 1'b1;

      case (state_q)
        SbaIdle: begin
          if (start) begin
            addr_q  <= sbaddress_i;
            size_q  <= sbaccess_i;
            we_q    <= start_wr;
            wdata_q <= sbdata_i;
            if (size_bad)        sberror_q <= SbErrBadSize;
            else if (misaligned) sberror_q <= SbErrMisaligned;
            else begin
              cnt_q   <= '0;
              state_q <= SbaReq;
            end
          end
        end
        SbaReq: begin
          cnt_q <= cnt_q + CntW'(1);
          // A granted request must still see its response, so it drains instead of idling.
          if (!dmactive_i)      state_q <= master_gnt_i ? SbaDrain : SbaIdle;
          else if (master_gnt_i) state_q <= SbaWait;
          else if (timeout_hit) begin
            sberror_q <= SbErrTimeout;
            state_q   <= SbaIdle;
          end
        end
        SbaWait: begin
          cnt_q <= cnt_q + CntW'(1);
          if (!dmactive_i) state_q <= master_r_valid_i ? SbaIdle : SbaDrain;
          else if (master_r_valid_i) begin
            if (master_r_err_i) sberror_q <= SbErrBadAddr;
            else begin
              if (!we_q) begin
                sbdata_q       <= BusWidth'(sba_lane_dn(128'(master_r_rdata_i), off, size_q));
                sbdata_valid_q <= 1'b1;
              end
              if (sbautoincrement_i) begin
                sbaddress_q       <= addr_q + (BusWidth'(1) << size_q);
                sbaddress_valid_q <= 1'b1;
              end
            end
            state_q <= SbaIdle;
          end else if (timeout_hit) begin
            sberror_q <= SbErrTimeout;
            state_q   <= SbaDrain;
          end
        end
        default: begin
          if (master_r_valid_i) state_q <= SbaIdle;
        end
      endcase

      if (!dmactive_i) begin
        sberror_q         <= SbErrNone;
        sbbusyerror_q     <= 1'b0;
        sbaddress_q       <= '0;
        sbaddress_valid_q <= 1'b0;
        sbdata_q          <= '0;
        sbdata_valid_q    <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  a_rvalid_not_on_gnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(master_req_o && master_gnt_i && master_r_valid_i))
    else $error("r_valid coincides with grant");
  a_rvalid_expected : assert property (@(posedge clk_i) disable iff (!rst_ni)
    master_r_valid_i |-> (state_q inside {SbaWait, SbaDrain}))
    else $error("r_valid outside Wait/Drain");
`endif

endmodule

// File: tb/tb_dm_sba_ctrl.sv
module tb_dm_sba_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dmactive = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 64-bit bus, short timeout.
  logic        req, we, gnt, r_valid, r_err;
  logic [63:0] add, wdata, rdata_in;
  logic [7:0]  be;
  logic [63:0] sbaddress, sbdata, sbaddress_out, sbdata_out;
  logic        sbaddress_write_valid, sbreadonaddr, sbautoinc, sbreadondata;
  logic        sbdata_read_valid, sbdata_write_valid;
  logic [2:0]  sbaccess, sberror;
  logic        sbaddress_valid, sbdata_valid, sbbusy, sbbusyerror;
  logic        sbbusyerror_clear, sberror_clear;

  // Second instance: 32-bit bus, timeout disabled, used for address wrap.
  logic        b_req, b_we, b_gnt, b_r_valid;
  logic [31:0] b_add, b_wdata, b_sbaddress, b_sbdata, b_sbaddress_out, b_sbdata_out;
  logic [3:0]  b_be;
  logic        b_sbdata_write_valid, b_sbaddress_valid, b_sbdata_valid, b_sbbusy, b_sbbusyerror;
  logic [2:0]  b_sberror;

  int checks = 0;
  int errors = 0;

  dm_sba_ctrl #(.BusWidth(64), .TimeoutCycles(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
    .master_req_o(req), .master_add_o(add), .master_we_o(we), .master_wdata_o(wdata),
    .master_be_o(be), .master_gnt_i(gnt), .master_r_valid_i(r_valid), .master_r_err_i(r_err),
    .master_r_rdata_i(rdata_in), .sbaddress_i(sbaddress),
    .sbaddress_write_valid_i(sbaddress_write_valid), .sbreadonaddr_i(sbreadonaddr),
    .sbautoincrement_i(sbautoinc), .sbaccess_i(sbaccess), .sbreadondata_i(sbreadondata),
    .sbdata_i(sbdata), .sbdata_read_valid_i(sbdata_read_valid),
    .sbdata_write_valid_i(sbdata_write_valid), .sbaddress_o(sbaddress_out),
    .sbaddress_valid_o(sbaddress_valid), .sbdata_o(sbdata_out), .sbdata_valid_o(sbdata_valid),
    .sbbusy_o(sbbusy), .sbbusyerror_o(sbbusyerror), .sbbusyerror_clear_i(sbbusyerror_clear),
    .sberror_o(sberror), .sberror_clear_i(sberror_clear)
  );

  dm_sba_ctrl #(.BusWidth(32), .TimeoutCycles(0)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
    .master_req_o(b_req), .master_add_o(b_add), .master_we_o(b_we), .master_wdata_o(b_wdata),
    .master_be_o(b_be), .master_gnt_i(b_gnt), .master_r_valid_i(b_r_valid), .master_r_err_i(1'b0),
    .master_r_rdata_i(32'h0), .sbaddress_i(b_sbaddress),
    .sbaddress_write_valid_i(1'b0), .sbreadonaddr_i(1'b0),
    .sbautoincrement_i(1'b1), .sbaccess_i(3'd2), .sbreadondata_i(1'b0),
    .sbdata_i(b_sbdata), .sbdata_read_valid_i(1'b0),
    .sbdata_write_valid_i(b_sbdata_write_valid), .sbaddress_o(b_sbaddress_out),
    .sbaddress_valid_o(b_sbaddress_valid), .sbdata_o(b_sbdata_out), .sbdata_valid_o(b_sbdata_valid),
    .sbbusy_o(b_sbbusy), .sbbusyerror_o(b_sbbusyerror), .sbbusyerror_clear_i(1'b0),
    .sberror_o(b_sberror), .sberror_clear_i(1'b0)
  );

  typedef struct {
    bit          done;
    bit          req_seen;
    logic [63:0] add;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
    int          dv_cnt;
    logic [63:0] dv_val;
    int          av_cnt;
    logic [63:0] av_val;
  } obs_t;

  // Reference model: byte-lane view of an access of nb bytes at address a.
  function automatic logic [7:0] ref_be(input logic [63:0] a, input int nb);
    int off = int'(a[2:0]);
    for (int b = 0; b < 8; b++) ref_be[b] = (b >= off) && (b < off + nb);
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] d, input logic [63:0] a, input int nb);
    int off = int'(a[2:0]);
    ref_wdata = '0;
    for (int i = 0; i < nb; i++) ref_wdata[8*(off+i) +: 8] = d[8*i +: 8];
  endfunction

  function automatic logic [63:0] ref_rdata(input logic [63:0] rd, input logic [63:0] a, input int nb);
    int off = int'(a[2:0]);
    ref_rdata = '0;
    for (int i = 0; i < nb; i++) ref_rdata[8*i +: 8] = rd[8*(off+i) +: 8];
  endfunction

  // Bus/debugger driver. mode: 0 write, 1 read-on-address, 2 read-on-data.
  task automatic do_xfer(input int mode, input logic [63:0] a, input logic [2:0] size,
                         input logic [63:0] d, input logic ainc, input int gnt_dly,
                         input int rv_dly, input logic err, input logic [63:0] rd,
                         output obs_t o);
    int req_cycles = 0, rv_cnt = 0, post = 0;
    bit granted = 0, sent = 0;
    o = '{default: 0};
    @(negedge clk);
    sbaddress = a; sbaccess = size; sbdata = d; sbautoinc = ainc;
    sbreadonaddr = (mode == 1); sbreadondata = (mode == 2);
    sbdata_write_valid = (mode == 0); sbaddress_write_valid = (mode == 1);
    sbdata_read_valid = (mode == 2);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sbdata_write_valid = 0; sbaddress_write_valid = 0; sbdata_read_valid = 0;
      gnt = 0; r_valid = 0; r_err = 0;
      if (sbdata_valid) begin o.dv_cnt++; o.dv_val = sbdata_out; end
      if (sbaddress_valid) begin o.av_cnt++; o.av_val = sbaddress_out; end
      if (sent) begin
        if (!sbbusy) begin
          post++;
          if (post == 2) begin o.done = 1; break; end
        end
      end else if (!granted) begin
        if (req) begin
          if (!o.req_seen) begin o.add = add; o.we = we; o.be = be; o.wdata = wdata; end
          o.req_seen = 1;
          if (req_cycles == gnt_dly) begin gnt = 1; granted = 1; end
          req_cycles++;
        end
      end else begin
        rv_cnt++;
        if (rv_cnt == rv_dly) begin r_valid = 1; r_err = err; rdata_in = rd; sent = 1; end
      end
    end
    gnt = 0; r_valid = 0; r_err = 0;
  endtask

  task automatic clear_sberror();
    @(negedge clk); sberror_clear = 1;
    @(negedge clk); sberror_clear = 0;
    checks++;
    if (sberror !== 3'd0) begin errors++; $display("FAIL sberror_clear: got %0d want 0", sberror); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({req, sbbusy, sbbusyerror, sbdata_valid, sbaddress_valid, sberror} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: req=%b busy=%b busyerr=%b dv=%b av=%b err=%0d want all 0",
               req, sbbusy, sbbusyerror, sbdata_valid, sbaddress_valid, sberror);
    end
    rst_n = 1; dmactive = 1;
    @(negedge clk);
  endtask

  task automatic test_write_directed();
    obs_t o;
    do_xfer(0, 64'h1004, 3'd2, 64'hDEAD_BEEF, 1'b1, 0, 1, 1'b0, 64'h0, o);
    checks++;
    if (!o.done || !o.req_seen) begin errors++; $display("FAIL wr_done: done=%b req=%b want 1 1", o.done, o.req_seen); end
    checks++;
    if (o.be !== 8'hF0) begin errors++; $display("FAIL wr_be: got %h want f0", o.be); end
    checks++;
    if (o.wdata !== 64'hDEAD_BEEF_0000_0000) begin errors++; $display("FAIL wr_wdata: got %h want deadbeef00000000", o.wdata); end
    checks++;
    if (o.add !== 64'h1004 || o.we !== 1'b1) begin errors++; $display("FAIL wr_addr_we: got %h/%b want 1004/1", o.add, o.we); end
    checks++;
    if (o.av_cnt !== 1 || o.av_val !== 64'h1008) begin errors++; $display("FAIL wr_autoinc: got %0d pulses %h want 1 pulse 1008", o.av_cnt, o.av_val); end
  endtask

  task automatic test_read_directed();
    obs_t o;
    do_xfer(1, 64'h2006, 3'd1, 64'h0, 1'b0, 0, 1, 1'b0, 64'h1234_5678_9ABC_DEF0, o);
    checks++;
    if (o.dv_cnt !== 1 || o.dv_val !== 64'h1234) begin errors++; $display("FAIL rd_data: got %0d pulses %h want 1 pulse 1234", o.dv_cnt, o.dv_val); end
    checks++;
    if (sberror !== 3'd0 || o.av_cnt !== 0) begin errors++; $display("FAIL rd_status: err=%0d av=%0d want 0 0", sberror, o.av_cnt); end
  endtask

  task automatic test_start_errors();
    bit req_seen = 0;
    @(negedge clk);
    sbaddress = 64'h2003; sbaccess = 3'd1; sbreadonaddr = 1; sbaddress_write_valid = 1;
    @(negedge clk); sbaddress_write_valid = 0; req_seen |= req;
    @(negedge clk); req_seen |= req;
    checks++;
    if (sberror !== 3'd3) begin errors++; $display("FAIL misaligned: got %0d want 3", sberror); end
    sbaddress = 64'h2000; sbdata_write_valid = 1;
    @(negedge clk); sbdata_write_valid = 0; req_seen |= req;
    @(negedge clk); req_seen |= req;
    checks++;
    if (req_seen || sberror !== 3'd3) begin errors++; $display("FAIL err_lockout: req=%b err=%0d want 0 3", req_seen, sberror); end
    clear_sberror();
    sbaddress = 64'h10; sbaccess = 3'd4; sbdata_write_valid = 1;
    @(negedge clk); sbdata_write_valid = 0;
    @(negedge clk);
    checks++;
    if (sberror !== 3'd4 || req !== 1'b0) begin errors++; $display("FAIL bad_size: err=%0d req=%b want 4 0", sberror, req); end
    clear_sberror();
  endtask

  task automatic test_random();
    obs_t o;
    for (int n = 0; n < 24; n++) begin
      int mode = $urandom_range(0, 2);
      logic [2:0] size = 3'($urandom_range(0, 3));
      int nb = 1 << size;
      logic [63:0] a = {$urandom, $urandom} & ~64'(nb - 1);
      logic [63:0] d = {$urandom, $urandom};
      logic [63:0] rd = {$urandom, $urandom};
      logic ainc = 1'($urandom_range(0, 1));
      if (nb < 8) d = d & ((64'd1 << (8 * nb)) - 1);
      do_xfer(mode, a, size, d, ainc, $urandom_range(0, 2), $urandom_range(1, 3), 1'b0, rd, o);
      checks++;
      if (!o.done || o.add !== a || o.we !== (mode == 0) || o.be !== ref_be(a, nb)) begin
        errors++;
        $display("FAIL rnd_req[%0d]: done=%b add=%h we=%b be=%h want 1 %h %b %h",
                 n, o.done, o.add, o.we, o.be, a, mode == 0, ref_be(a, nb));
      end
      checks++;
      if (mode == 0 && o.wdata !== ref_wdata(d, a, nb)) begin
        errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, o.wdata, ref_wdata(d, a, nb));
      end
      checks++;
      if ((mode == 0 && o.dv_cnt !== 0) ||
          (mode != 0 && (o.dv_cnt !== 1 || o.dv_val !== ref_rdata(rd, a, nb)))) begin
        errors++; $display("FAIL rnd_rdata[%0d]: got %0d pulses %h want %h", n, o.dv_cnt, o.dv_val, ref_rdata(rd, a, nb));
      end
      checks++;
      if (o.av_cnt !== int'(ainc) || (ainc && o.av_val !== a + 64'(nb)) || sberror !== 3'd0) begin
        errors++; $display("FAIL rnd_autoinc[%0d]: got %0d pulses %h err %0d want %0d %h 0", n, o.av_cnt, o.av_val, sberror, ainc, a + 64'(nb));
      end
    end
  endtask

  task automatic test_bus_error();
    obs_t o;
    do_xfer(2, 64'h300, 3'd3, 64'h0, 1'b1, 1, 2, 1'b1, 64'hFFFF, o);
    checks++;
    if (sberror !== 3'd2 || o.dv_cnt !== 0 || o.av_cnt !== 0) begin
      errors++; $display("FAIL bus_error: err=%0d dv=%0d av=%0d want 2 0 0", sberror, o.dv_cnt, o.av_cnt);
    end
    clear_sberror();
  endtask

  task automatic test_timeout();
    int k = 0;
    bit dv_seen = 0;
    @(negedge clk);
    sbaddress = 64'h500; sbaccess = 3'd2; sbdata_write_valid = 1;
    @(negedge clk); sbdata_write_valid = 0; gnt = 1;
    while (k < 30) begin
      @(negedge clk); gnt = 0; k++;
      if (sberror !== 3'd0) break;
    end
    checks++;
    if (k !== 8 || sberror !== 3'd1) begin errors++; $display("FAIL timeout_cycle: got cycle %0d err %0d want 8 1", k, sberror); end
    @(negedge clk); @(negedge clk);
    checks++;
    if (sbbusy !== 1'b1) begin errors++; $display("FAIL timeout_drain: busy=%b want 1", sbbusy); end
    r_valid = 1; rdata_in = 64'hAAAA;
    @(negedge clk); r_valid = 0; dv_seen |= sbdata_valid;
    @(negedge clk); dv_seen |= sbdata_valid;
    checks++;
    if (sbbusy !== 1'b0 || dv_seen) begin errors++; $display("FAIL timeout_late_rvalid: busy=%b dv=%b want 0 0", sbbusy, dv_seen); end
    clear_sberror();
  endtask

  task automatic test_busy_error();
    @(negedge clk);
    sbaddress = 64'h3000; sbaccess = 3'd2; sbautoinc = 1; sbdata_write_valid = 1;
    @(negedge clk); sbdata_write_valid = 0; gnt = 1;
    @(negedge clk); gnt = 0; sbdata_write_valid = 1; sbbusyerror_clear = 1;
    @(negedge clk); sbdata_write_valid = 0; sbbusyerror_clear = 0;
    checks++;
    if (sbbusyerror !== 1'b1 || sbbusy !== 1'b1) begin errors++; $display("FAIL busyerr_set: busyerr=%b busy=%b want 1 1", sbbusyerror, sbbusy); end
    r_valid = 1;
    @(negedge clk); r_valid = 0;
    checks++;
    if (sbaddress_valid !== 1'b1 || sbaddress_out !== 64'h3004 || sbbusy !== 1'b0) begin
      errors++; $display("FAIL busyerr_completes: av=%b addr=%h busy=%b want 1 3004 0", sbaddress_valid, sbaddress_out, sbbusy);
    end
    sbdata_write_valid = 1;
    @(negedge clk); sbdata_write_valid = 0;
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL busyerr_lockout: req=%b want 0", req); end
    sbbusyerror_clear = 1;
    @(negedge clk); sbbusyerror_clear = 0;
    checks++;
    if (sbbusyerror !== 1'b0) begin errors++; $display("FAIL busyerr_clear: got %b want 0", sbbusyerror); end
  endtask

  task automatic test_dmactive_drop();
    bit busy_ok = 1, dv_seen = 0;
    @(negedge clk);
    sbaddress = 64'h40; sbaccess = 3'd3; sbreadonaddr = 1; sbaddress_write_valid = 1;
    @(negedge clk); sbaddress_write_valid = 0; gnt = 1;
    @(negedge clk); gnt = 0; dmactive = 0;
    repeat (3) begin
      @(negedge clk); busy_ok &= (sbbusy === 1'b1); dv_seen |= sbdata_valid;
    end
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL dmactive_busy: busy dropped early, want 1 until r_valid"); end
    r_valid = 1; rdata_in = {$urandom, $urandom};
    @(negedge clk); r_valid = 0; dv_seen |= sbdata_valid;
    checks++;
    if (sbbusy !== 1'b0 || sberror !== 3'd0 || sbbusyerror !== 1'b0 || dv_seen) begin
      errors++; $display("FAIL dmactive_drain: busy=%b err=%0d busyerr=%b dv=%b want 0 0 0 0", sbbusy, sberror, sbbusyerror, dv_seen);
    end
    dmactive = 1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    sbaddress = 64'h80; sbaccess = 3'd2; sbdata_write_valid = 1;
    @(negedge clk); sbdata_write_valid = 0;
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL arst_pre: req=%b want 1", req); end
    #2 rst_n = 0;
    #1;
    checks++;
    if (req !== 1'b0 || sbbusy !== 1'b0) begin errors++; $display("FAIL arst_req: req=%b busy=%b want 0 0", req, sbbusy); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_wrap32();
    @(negedge clk);
    b_sbaddress = 32'hFFFF_FFFC; b_sbdata = 32'h0BAD_F00D; b_sbdata_write_valid = 1;
    @(negedge clk); b_sbdata_write_valid = 0;
    checks++;
    if (b_req !== 1'b1 || b_be !== 4'hF || b_wdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL wrap_req: req=%b be=%h wdata=%h want 1 f 0badf00d", b_req, b_be, b_wdata);
    end
    b_gnt = 1;
    @(negedge clk); b_gnt = 0; b_r_valid = 1;
    @(negedge clk); b_r_valid = 0;
    checks++;
    if (b_sbaddress_valid !== 1'b1 || b_sbaddress_out !== 32'h0) begin
      errors++; $display("FAIL wrap_addr: av=%b addr=%h want 1 0", b_sbaddress_valid, b_sbaddress_out);
    end
  endtask

  initial begin
    {gnt, r_valid, r_err, sbaddress_write_valid, sbreadonaddr, sbautoinc, sbreadondata} = '0;
    {sbdata_read_valid, sbdata_write_valid, sbbusyerror_clear, sberror_clear} = '0;
    rdata_in = '0; sbaddress = '0; sbdata = '0; sbaccess = '0;
    b_gnt = 0; b_r_valid = 0; b_sbaddress = '0; b_sbdata = '0; b_sbdata_write_valid = 0;
    test_reset();
    test_write_directed();
    test_read_directed();
    test_start_errors();
    test_random();
    test_bus_error();
    test_timeout();
    test_busy_error();
    test_dmactive_drop();
    test_async_reset();
    test_wrap32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
